// File: rtl/aes_pkg.sv
// Shared AES constants, types, S-box and Rcon tables for the key-schedule datapath.
package aes_pkg;

  localparam int NK             = 6;
  localparam int NR             = 12;
  localparam int NUM_ROUND_KEYS = 13;
  localparam int RC_W           = $clog2(NUM_ROUND_KEYS);

  typedef logic [31:0]  word_t;
  typedef logic [127:0] round_key_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 and everything above 8 are never consumed; zero keeps the lookup total.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON[idx];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = sbox(din);

endmodule

// File: rtl/aes_key_expansion_192.sv
// Iterative AES-192 key schedule: 13 round keys, one per clock after start.
// Optional AES_KEYEXP_ROUND_IDX_EN adds a registered round_idx output.
module aes_key_expansion_192
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [191:0] short_key,
  output logic [127:0] subkey,
  output logic         rdy
`ifdef AES_KEYEXP_ROUND_IDX_EN
  ,
  output logic [3:0]   round_idx
`endif
);

  state_t            state_p0;
  logic [RC_W-1:0]   rc_p0;
  word_t             win_p0 [NK];
  word_t             nw_p0 [4];

  logic [7:0]        base;
  logic [7:0]        base_mod;
  logic [2:0]        sel;
  logic [3:0]        rcon_idx;
  word_t             sub_in;
  word_t             rot_word;
  word_t             sub_word;
  word_t             chain;

  // Window holds w[4(rc-1) .. 4(rc-1)+5]; the four new words start at index 4rc+2.
  // sel is the position among them that is a multiple of 6 (values 4/5 mean none).
  always_comb begin
    base     = 8'({rc_p0, 2'b00}) + 8'd2;
    base_mod = base % 8'd6;
    sel      = (base_mod == 8'd0) ? 3'd0 : 3'(8'd6 - base_mod);
    rcon_idx = 4'((base + {5'd0, sel}) / 8'd6);
  end

  // Word preceding the S-box position, unrolled from the window so the S-box
  // input does not depend on its own output through the chain.
  always_comb begin
    sub_in = win_p0[NK-1];
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < sel) sub_in = sub_in ^ win_p0[k];
    end
  end

  assign rot_word = {sub_in[23:0], sub_in[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_word[8*j +: 8]),
      .dout (sub_word[8*j +: 8])
    );
  end

  always_comb begin
    chain = win_p0[NK-1];
    for (int k = 0; k < 4; k++) begin
      if (3'(k) == sel) chain = sub_word ^ {rcon(rcon_idx), 24'h000000};
      nw_p0[k] = win_p0[k] ^ chain;
      chain    = nw_p0[k];
    end
  end

  // ---- stage boundary: window, counter and registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      rc_p0    <= '0;
      rdy      <= 1'b0;
      subkey   <= '0;
      for (int i = 0; i < NK; i++) win_p0[i] <= '0;
`ifdef AES_KEYEXP_ROUND_IDX_EN
      round_idx <= '0;
`endif
    end else begin
      case (state_p0)
        IDLE: begin
          rdy <= 1'b0;
          if (start) begin
            state_p0 <= RUN;
            rc_p0    <= '0;
            for (int i = 0; i < NK; i++) win_p0[i] <= short_key[191-32*i -: 32];
          end
        end
        RUN: begin
          rdy <= 1'b1;
`ifdef AES_KEYEXP_ROUND_IDX_EN
          round_idx <= 4'(rc_p0);
`endif
          if (rc_p0 == '0) begin
            subkey <= {win_p0[0], win_p0[1], win_p0[2], win_p0[3]};
          end else begin
            subkey    <= {win_p0[4], win_p0[5], nw_p0[0], nw_p0[1]};
            win_p0[0] <= win_p0[4];
            win_p0[1] <= win_p0[5];
            win_p0[2] <= nw_p0[0];
            win_p0[3] <= nw_p0[1];
            win_p0[4] <= nw_p0[2];
            win_p0[5] <= nw_p0[3];
          end
          if (rc_p0 == RC_W'(NR)) state_p0 <= IDLE;
          else                    rc_p0    <= rc_p0 + 1'b1;
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expansion_192.sv
// Scoreboard bench for aes_key_expansion_192 against a word-array key-schedule model.
module tb_aes_key_expansion_192;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [191:0] short_key;
  logic [127:0] subkey;
  logic         rdy;
`ifdef AES_KEYEXP_ROUND_IDX_EN
  logic [3:0]   round_idx;
`endif

  always #5 clk = ~clk;

  aes_key_expansion_192 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .short_key (short_key),
    .subkey    (subkey),
    .rdy       (rdy)
`ifdef AES_KEYEXP_ROUND_IDX_EN
    ,
    .round_idx (round_idx)
`endif
  );

  typedef struct {
    logic [127:0] key;
    int           idx;
  } exp_t;

  exp_t         exp_q [$];
  logic [127:0] obs [$];
  logic [7:0]   sb [256];
  logic [127:0] model_r0, model_r12;
  int           checks = 0;
  int           failures = 0;

  localparam logic [191:0] KEY_A2   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] A2_R0    = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] A2_R1    = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] A2_R12   = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] ZERO_R1  = 128'h00000000000000006263636362636363;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(i), 8'(x)) == 8'h01) inv = 8'(x);
      sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expected(input logic [191:0] key);
    logic [31:0] w [52];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    rc = 8'h01;
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) begin
      exp_t e;
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.idx = r;
      exp_q.push_back(e);
    end
    model_r0  = {w[0], w[1], w[2], w[3]};
    model_r12 = {w[48], w[49], w[50], w[51]};
  endtask

  function automatic logic [191:0] rand192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check128(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rdy cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rdy actual=%h required=no_output", subkey);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (subkey !== e.key) begin
          failures++;
          $display("FAIL subkey_r%0d actual=%h required=%h", e.idx, subkey, e.key);
        end
`ifdef AES_KEYEXP_ROUND_IDX_EN
        checks++;
        if (round_idx !== 4'(e.idx)) begin
          failures++;
          $display("FAIL round_idx actual=%0d required=%0d", round_idx, e.idx);
        end
`endif
        obs.push_back(subkey);
      end
    end
  end

  task automatic run_pulse(input logic [191:0] key, input string nm);
    int n;
    obs.delete();
    short_key = key;
    start     = 1'b1;
    push_expected(key);
    tick();
    start     = 1'b0;
    short_key = rand192();
    n = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (rdy === 1'b1) n++;
    end
    check_int({nm, "_rdy_cycles"}, n, 13);
    check_int({nm, "_obs_count"}, obs.size(), 13);
    check128({nm, "_hold_r12"}, subkey, model_r12);
    check_int({nm, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] k1, k2;
    logic [127:0] k1_r12, k2_r0;
    int bad;

    build_sbox();
    reset = 1'b1; start = 1'b0; short_key = '0;
    repeat (3) tick();
    check_int("reset_rdy", int'(rdy), 0);
    check128("reset_subkey", subkey, '0);
`ifdef AES_KEYEXP_ROUND_IDX_EN
    check_int("reset_round_idx", int'(round_idx), 0);
`endif
    reset = 1'b0;
    tick();

    // FIPS-197 A.2 vector
    run_pulse(KEY_A2, "a2");
    if (obs.size() >= 13) begin
      check128("a2_r0", obs[0], A2_R0);
      check128("a2_r1", obs[1], A2_R1);
      check128("a2_r12", obs[12], A2_R12);
    end

    // all-zero key
    run_pulse('0, "zero");
    if (obs.size() >= 13) begin
      check128("zero_r0", obs[0], '0);
      check128("zero_r1", obs[1], ZERO_R1);
    end
    repeat (3) tick();
    check_int("zero_idle_rdy", int'(rdy), 0);
    check128("zero_idle_hold", subkey, model_r12);

    // start held high: back-to-back runs with a single gap cycle
    k1 = rand192(); k2 = rand192();
    obs.delete();
    short_key = k1; start = 1'b1;
    push_expected(k1);
    k1_r12 = model_r12;
    tick();
    short_key = k2;
    push_expected(k2);
    k2_r0 = model_r0;
    bad = 0;
    for (int t = 1; t <= 28; t++) begin
      tick();
      if (rdy !== ((t != 14) && (t != 28))) bad++;
      if (t == 14) begin
        check128("held_gap_hold", subkey, k1_r12);
        start = 1'b0;
      end
      if (t == 15) check128("held_second_r0", subkey, k2_r0);
    end
    check_int("held_rdy_pattern_errors", bad, 0);
    check_int("held_scoreboard_empty", exp_q.size(), 0);

    // start and new key mid-run are ignored
    k1 = rand192();
    obs.delete();
    short_key = k1; start = 1'b1;
    push_expected(k1);
    tick();
    start = 1'b0;
    repeat (5) tick();
    short_key = rand192(); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check_int("midrun_obs_count", obs.size(), 13);
    check_int("midrun_scoreboard_empty", exp_q.size(), 0);
    check_int("midrun_idle_rdy", int'(rdy), 0);

    // reset while round key 5 is presented
    k1 = rand192();
    obs.delete();
    short_key = k1; start = 1'b1;
    push_expected(k1);
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    exp_q.delete();
    check_int("rst_mid_rdy", int'(rdy), 0);
    check128("rst_mid_subkey", subkey, '0);
    check_int("rst_mid_obs_count", obs.size(), 6);
`ifdef AES_KEYEXP_ROUND_IDX_EN
    check_int("rst_mid_round_idx", int'(round_idx), 0);
`endif
    reset = 1'b0;
    tick();
    k2 = rand192();
    run_pulse(k2, "post_rst");
    if (obs.size() >= 1) check128("post_rst_r0", obs[0], model_r0);

    // randomized keys with random idle gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_pulse(rand192(), "rand");
    end

    repeat (2) tick();
    check_int("final_scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
